// File: rtl/sprite_pkg.sv
// Shared sizing and requester ids for the sprite ROM arbiter.
// Requester ids map onto the round-robin slots of the arbiter.
package sprite_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 4;
  localparam int WAIT_W     = 8;

  localparam int REQ_TANK0  = 0;
  localparam int REQ_TANK1  = 1;
  localparam int REQ_BULLET = 2;
  localparam int REQ_BG     = 3;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at ptr, ptr+1, ...
// Scanning high-to-low lets the lowest offset overwrite later hits.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        win_o    = '0;
        win_o[j] = 1'b1;
        idx_o    = PW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM.
// Grant is same-cycle; read data returns with rvalid one cycle later.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    vga_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]  tag_q, tag_d;
  logic [N_REQ-1:0]  win;
  logic [PW-1:0]     idx;
  logic              any;
  logic [WAIT_W-1:0] wait_q [N_REQ];
  logic [WAIT_W-1:0] wait_d [N_REQ];

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (idx),
    .any_o (any)
  );

  always_comb begin
    gnt         = reset ? '0 : win;
    rom_address = '0;
    if (any && !reset)
      rom_address = req_addr[int'(idx)*ADDR_W +: ADDR_W];
    ptr_d = ptr_q;
    if (any)
      ptr_d = PW'(wrap_inc(int'(idx), N_REQ));
    tag_d = gnt;
    for (int i = 0; i < N_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (gnt[i])
        wait_d[i] = '0;
      else if (req[i] && wait_q[i] != '1)
        wait_d[i] = wait_q[i] + 1'b1;
    end
  end

  // Reset also masks the tag already in flight so that read is dropped.
  always_comb begin
    rvalid = reset ? '0 : tag_q;
    rdata  = (|rvalid) ? rom_q : '0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ptr_q <= '0;
      tag_q <= '0;
      for (int i = 0; i < N_REQ; i++)
        wait_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      for (int i = 0; i < N_REQ; i++)
        wait_q[i] <= wait_d[i];
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_wait_chk
    a_wait_bound: assert property (
      @(posedge vga_clk) disable iff (reset)
      wait_q[g] < WAIT_W'(N_REQ)
    );
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed-vector and scoreboard bench for sprite_rom_arbiter.
// Bench owns a synchronous ROM model driven by rom_address.
module tb_sprite_rom_arbiter;

  localparam int N = 4;
  localparam int AW = 10;
  localparam int DW = 4;

  logic            vga_clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   rom_address;
  logic [DW-1:0]   rom_q;

  int nvec = 0;
  int nerr = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]} ^ 4'h5;
  endfunction

  always @(posedge vga_clk) rom_q <= rom_f(rom_address);

  typedef struct {
    logic          rst;
    logic [N-1:0]  rq;
    logic [N-1:0]  egnt;
    logic [AW-1:0] eaddr;
    logic [N-1:0]  erv;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tv[$];

  localparam logic [AW-1:0] A0 = 10'd37;
  localparam logic [AW-1:0] A1 = 10'd100;
  localparam logic [AW-1:0] A2 = 10'd513;
  localparam logic [AW-1:0] A3 = 10'd1023;

  task automatic add(input logic r, input logic [N-1:0] q,
                     input logic [N-1:0] g, input logic [AW-1:0] a,
                     input logic [N-1:0] v, input logic [DW-1:0] d);
    vec_t t;
    t.rst = r; t.rq = q; t.egnt = g;
    t.eaddr = a; t.erv = v; t.erd = d;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [N-1:0]  pend;
  logic [AW-1:0] paddr [N];
  int            wt [N];
  int            ptr_m;
  int            w;
  logic [N-1:0]  eg;
  logic [N-1:0]  etag;
  logic [DW-1:0] edata;

  initial begin
    reset = 1'b1;
    req = '0;
    req_addr = {A3, A2, A1, A0};

    // idle/ptr hold, full rotation, wrap, reset drop
    add(0, 4'b0001, 4'b0001, A0, 4'b0000, 4'h0);
    add(0, 4'b0000, 4'b0000, 0,  4'b0001, rom_f(A0));
    add(0, 4'b0000, 4'b0000, 0,  4'b0000, 4'h0);
    add(0, 4'b0000, 4'b0000, 0,  4'b0000, 4'h0);
    add(0, 4'b0000, 4'b0000, 0,  4'b0000, 4'h0);
    add(0, 4'b0000, 4'b0000, 0,  4'b0000, 4'h0);
    add(0, 4'b1111, 4'b0010, A1, 4'b0000, 4'h0);
    add(1, 4'b1111, 4'b0000, 0,  4'b0000, 4'h0);
    add(0, 4'b1111, 4'b0001, A0, 4'b0000, 4'h0);
    add(0, 4'b1111, 4'b0010, A1, 4'b0001, rom_f(A0));
    add(0, 4'b1111, 4'b0100, A2, 4'b0010, rom_f(A1));
    add(0, 4'b1111, 4'b1000, A3, 4'b0100, rom_f(A2));
    add(0, 4'b1111, 4'b0001, A0, 4'b1000, rom_f(A3));
    add(0, 4'b1111, 4'b0010, A1, 4'b0001, rom_f(A0));
    add(0, 4'b1111, 4'b0100, A2, 4'b0010, rom_f(A1));
    add(0, 4'b1111, 4'b1000, A3, 4'b0100, rom_f(A2));
    add(0, 4'b0100, 4'b0100, A2, 4'b1000, rom_f(A3));
    add(0, 4'b0101, 4'b0001, A0, 4'b0100, rom_f(A2));
    add(0, 4'b0100, 4'b0100, A2, 4'b0001, rom_f(A0));
    add(0, 4'b0000, 4'b0000, 0,  4'b0100, rom_f(A2));
    add(0, 4'b1001, 4'b1000, A3, 4'b0000, 4'h0);
    add(0, 4'b0010, 4'b0010, A1, 4'b1000, rom_f(A3));
    add(1, 4'b0000, 4'b0000, 0,  4'b0000, 4'h0);
    add(0, 4'b0000, 4'b0000, 0,  4'b0000, 4'h0);
    add(0, 4'b0010, 4'b0010, A1, 4'b0000, 4'h0);
    add(0, 4'b0000, 4'b0000, 0,  4'b0010, rom_f(A1));

    @(posedge vga_clk);
    @(posedge vga_clk);
    foreach (tv[i]) begin
      @(posedge vga_clk); #1;
      reset = tv[i].rst;
      req   = tv[i].rq;
      @(negedge vga_clk);
      chk($sformatf("v%0d.gnt", i), 32'(gnt), 32'(tv[i].egnt));
      chk($sformatf("v%0d.addr", i), 32'(rom_address), 32'(tv[i].eaddr));
      chk($sformatf("v%0d.rvalid", i), 32'(rvalid), 32'(tv[i].erv));
      chk($sformatf("v%0d.rdata", i), 32'(rdata), 32'(tv[i].erd));
    end

    // scoreboard phase: random requests held until granted
    @(posedge vga_clk); #1;
    reset = 1'b1; req = '0;
    pend = '0; ptr_m = 0; etag = '0; edata = '0;
    for (int i = 0; i < N; i++) begin
      wt[i] = 0; paddr[i] = '0;
    end
    for (int c = 0; c < 10000; c++) begin
      @(posedge vga_clk); #1;
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom);
        end
        req_addr[i*AW +: AW] = pend[i] ? paddr[i] : AW'($urandom);
      end
      req = pend;
      @(negedge vga_clk);
      eg = '0; w = -1;
      for (int k = N - 1; k >= 0; k--)
        if (pend[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      if (w >= 0) eg[w] = 1'b1;
      chk("rnd.gnt", 32'(gnt), 32'(eg));
      chk("rnd.addr", 32'(rom_address), 32'((w >= 0) ? paddr[w] : '0));
      chk("rnd.rvalid", 32'(rvalid), 32'(etag));
      chk("rnd.rdata", 32'(rdata), 32'((etag != 0) ? edata : '0));
      etag = eg;
      edata = '0;
      for (int i = 0; i < N; i++)
        if (pend[i] && i != w) wt[i]++;
      if (w >= 0) begin
        edata = rom_f(paddr[w]);
        chk("rnd.wait", 32'(wt[w] <= N - 1), 32'd1);
        wt[w] = 0;
        pend[w] = 1'b0;
        ptr_m = (w + 1) % N;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 10, ROM address width.
REQ-003 SHALL have parameter DATA_W, default 4, ROM data (palette index) width.
REQ-004 SHALL have port vga_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  N_REQ  per-requester read request, one bit per requester.
REQ-007 SHALL have port req_addr  input  N_REQ*ADDR_W  packed request addresses; slice i belongs to requester i.
REQ-008 SHALL have port gnt  output  N_REQ  one-hot grant, combinational, same cycle as the accepted req.
REQ-009 SHALL have port rvalid  output  N_REQ  one-hot, registered; marks rdata valid for requester i.
REQ-010 SHALL have port rdata  output  DATA_W  read data shared by all requesters, qualified by rvalid.
REQ-011 SHALL have port rom_address  output  ADDR_W  address to the shared synchronous ROM.
REQ-012 SHALL have port rom_q  input  DATA_W  ROM output, valid one vga_clk after rom_address.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt SHALL be all-zero when req is all-zero or reset is high.
REQ-014 SHALL select the winner round-robin: first asserted req at index ptr, ptr+1, ..., wrapping modulo N_REQ.
REQ-015 SHALL update ptr to (winner+1) mod N_REQ after each grant; ptr SHALL hold on cycles with no grant.
REQ-016 SHALL drive rom_address with req_addr slice of the winner when granted, else all-zero.
REQ-017 SHALL accept a request only in the cycle gnt[i]=1; requester holds req/req_addr until then; a granted requester keeping req high re-competes next cycle.
REQ-018 SHALL register the winner one-hot into an in-flight tag; rvalid SHALL equal that tag one cycle after the grant.
REQ-019 SHALL present rdata = rom_q combinationally during the rvalid cycle and all-zero when rvalid is all-zero.
REQ-020 SHALL sustain one grant per cycle (full throughput); back-to-back grants give back-to-back rvalid pulses.
REQ-021 SHALL bound wait: a continuously asserted req SHALL be granted within N_REQ cycles.
REQ-022 SHALL keep a saturating 8-bit per-requester wait counter: increments each cycle req[i]=1 and gnt[i]=0, clears on gnt[i]; SHALL never exceed N_REQ-1 (internal, assertion-checked).
REQ-023 SHALL ignore req_addr of non-granted requesters; no X propagation from unused slices.

Reset
REQ-024 SHALL, in any cycle with reset high, set ptr=0, in-flight tag=0, wait counters=0.
REQ-025 SHALL force gnt=0, rom_address=0 while reset high; rvalid=0, rdata=0 in the cycle after reset.
REQ-026 SHALL drop a read in flight when reset asserts mid-operation: no rvalid for a grant issued before reset.
REQ-027 SHALL arbitrate normally from the first cycle after reset deasserts, starting at requester 0.

Structure
REQ-028 SHALL place N_REQ, ADDR_W, DATA_W defaults and requester-index constants (e.g. REQ_TANK0, REQ_TANK1, REQ_BULLET, REQ_BG) in shared package sprite_pkg.
REQ-029 SHALL use one sub-module rr_pick: combinational round-robin picker (req, ptr -> one-hot winner, winner index, any).
REQ-030 SHALL not instantiate the ROM; the existing ROM instance connects at the parent.

Verification
REQ-031 Reset, then req=4'b0001, addr0=10'd37 -> gnt=0001, rom_address=37; next cycle rvalid=0001, rdata=ROM[37].
REQ-032 req=4'b1111 held 8 cycles from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,... ; rvalid same sequence lagging 1 cycle.
REQ-033 ptr=3 (after granting 2), req=4'b0101 -> gnt=0001 (wrap), then 0100; ptr ends at 3.
REQ-034 Reset asserted the cycle after gnt=0010 -> rvalid stays 0000, rdata=0; after release req=4'b0010 -> granted first cycle.
REQ-035 Random req/addr, 10000 cycles vs scoreboard model -> every accepted request returns exactly one rvalid with ROM[addr]; no wait exceeds 3 cycles.
REQ-036 req=0 for 5 cycles -> gnt=0, rom_address=0, rvalid=0, ptr unchanged.
